// File: rtl/eu_xbuf_mp_pkg.sv
// eu_xbuf_mp_pkg: shared types for the execution-unit exchange buffer.
//   type_exec_unit_addr   : result tag carried with every exec-unit result
//   type_exec_unit_data   : result payload
//   type_eu_xbuf_mp_entry : one buffer slot (valid, tag, payload, reads left)
// reads_left is declared at the widest supported counter width; instances
// with a narrower NREADS_W zero-extend into it.
package eu_xbuf_mp_pkg;

  localparam int EU_ADDR_W        = 8;
  localparam int EU_DATA_W        = 16;
  localparam int EU_XBUF_NREADS_W = 4;

  typedef logic [EU_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EU_DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    logic                        valid;
    type_exec_unit_addr          addr;
    type_exec_unit_data          data;
    logic [EU_XBUF_NREADS_W-1:0] reads_left;
  } type_eu_xbuf_mp_entry;

endpackage

// File: rtl/eu_xbuf_alloc.sv
// eu_xbuf_alloc: lowest-index free-slot priority encoder.
//   valid    : per-slot valid bits
//   idx      : index of the lowest invalid slot (0 when none free)
//   any_free : at least one slot is invalid
module eu_xbuf_alloc
  import eu_xbuf_mp_pkg::*;
#(
  parameter int NUM_IDX_BITS = 2
) (
  input  logic [2**NUM_IDX_BITS-1:0] valid,
  output logic [NUM_IDX_BITS-1:0]    idx,
  output logic                       any_free
);

  // Scan downward so the last assignment made is the lowest free index.
  always_comb begin
    idx      = '0;
    any_free = 1'b0;
    for (int i = 2**NUM_IDX_BITS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        idx      = NUM_IDX_BITS'(i);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eu_xbuf_mp.sv
// eu_xbuf_mp: fully associative, address-tagged exchange buffer with
// multiple read ports. Each entry is freed after its programmed number of
// reads has been granted.
//   clk, reset_n  : clock, asynchronous active-low reset
//   in_*          : result write (tag, data, read count, valid) / in_ready_o
//   req_*         : per-port read request (tag, valid)
//   resp_*        : per-port registered response (data, valid), latency 1
//   occupancy_o   : number of valid entries
//   full_o        : all entries valid
module eu_xbuf_mp
  import eu_xbuf_mp_pkg::*;
#(
  parameter int NUM_IDX_BITS = 2,
  parameter int NUM_RD_PORTS = 2,
  parameter int NREADS_W     = 2
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic [EU_ADDR_W-1:0]                   in_addr_i,
  input  logic [EU_DATA_W-1:0]                   in_data_i,
  input  logic [NREADS_W-1:0]                    in_nreads_i,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [NUM_RD_PORTS-1:0][EU_ADDR_W-1:0] req_addr_i,
  input  logic [NUM_RD_PORTS-1:0]                req_valid_i,
  output logic [NUM_RD_PORTS-1:0][EU_DATA_W-1:0] resp_data_o,
  output logic [NUM_RD_PORTS-1:0]                resp_valid_o,
  output logic [NUM_IDX_BITS:0]                  occupancy_o,
  output logic                                   full_o
);

  localparam int DEPTH = 2**NUM_IDX_BITS;

  type_eu_xbuf_mp_entry entries_q [DEPTH];
  logic [NUM_IDX_BITS:0] occ_q;

  logic [DEPTH-1:0]        valid_vec;
  logic                    tag_hit;
  logic [NUM_IDX_BITS-1:0] free_idx;
  logic                    any_free;
  logic                    accept;

  logic [NUM_RD_PORTS-1:0]                grant;
  logic [NUM_RD_PORTS-1:0][EU_DATA_W-1:0] gdata;
  logic [EU_XBUF_NREADS_W-1:0]            rem_next [DEPTH];
  logic [DEPTH-1:0]                       freed;
  logic [NUM_IDX_BITS:0]                  n_freed;

  always_comb begin
    valid_vec = '0;
    tag_hit   = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      valid_vec[e] = entries_q[e].valid;
      if (entries_q[e].valid && entries_q[e].addr == in_addr_i) tag_hit = 1'b1;
    end
  end

  eu_xbuf_alloc #(.NUM_IDX_BITS(NUM_IDX_BITS)) u_alloc (
    .valid    (valid_vec),
    .idx      (free_idx),
    .any_free (any_free)
  );

  assign full_o      = (occ_q == (NUM_IDX_BITS+1)'(DEPTH));
  assign occupancy_o = occ_q;
  // Gated by reset_n so the port reads as not-ready while held in reset.
  assign in_ready_o  = reset_n & any_free & ~full_o & ~tag_hit & (in_nreads_i != '0);
  assign accept      = in_valid_i & in_ready_o;

  // Per entry, walk the ports in ascending order and hand out grants while
  // reads remain; ports beyond the remaining count see a miss.
  always_comb begin
    logic [EU_XBUF_NREADS_W-1:0] rem;
    grant   = '0;
    gdata   = '0;
    freed   = '0;
    n_freed = '0;
    rem     = '0;
    for (int e = 0; e < DEPTH; e++) begin
      rem = entries_q[e].reads_left;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (req_valid_i[p] && entries_q[e].valid &&
            entries_q[e].addr == req_addr_i[p] && rem != '0) begin
          grant[p] = 1'b1;
          gdata[p] = entries_q[e].data;
          rem      = rem - 1'b1;
        end
      end
      rem_next[e] = rem;
      freed[e]    = entries_q[e].valid && (rem == '0);
      n_freed     = n_freed + (NUM_IDX_BITS+1)'(freed[e]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < DEPTH; e++) entries_q[e] <= '0;
      occ_q        <= '0;
      resp_valid_o <= '0;
      resp_data_o  <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (entries_q[e].valid) begin
          entries_q[e].reads_left <= rem_next[e];
          if (freed[e]) entries_q[e].valid <= 1'b0;
        end
      end
      // free_idx always points at a slot that is invalid this cycle, so the
      // load never collides with a consume above.
      if (accept) begin
        entries_q[free_idx] <= '{valid:      1'b1,
                                 addr:       in_addr_i,
                                 data:       in_data_i,
                                 reads_left: EU_XBUF_NREADS_W'(in_nreads_i)};
      end
      occ_q        <= occ_q + (NUM_IDX_BITS+1)'(accept) - n_freed;
      resp_valid_o <= grant;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (grant[p]) resp_data_o[p] <= gdata[p];
      end
    end
  end

endmodule
